fabric_config_ctrl: RTL

FABRIC_CONFIG_CTRL -- requirements
Module: fabric_config_ctrl

---
 rtl/fabric_config_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/fabric_config_ctrl.sv
// Serial configuration sequencer: resets the fabric, shifts a CPU-fed bitstream
// MSB-first on a divided programming clock, then pulses the latch strobe.
module fabric_config_ctrl #(
  parameter int CLK_DIV      = 2,
  parameter int RESET_CYCLES = 4,
  parameter int LATCH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] total_bits,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic        head,
  output logic        programming_clock,
  output logic        set,
  output logic        p_reset
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FRESET = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_LATCH  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV);
  localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES);
  localparam logic [15:0] LAT_LAST = 16'(LATCH_CYCLES);

  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [15:0] bits_left_r, bits_left_s;
  logic [31:0] sh_r, sh_s;
  logic [31:0] hold_r, hold_s;
  logic [5:0]  sh_cnt_r, sh_cnt_s;
  logic        hold_empty_r, hold_empty_s;
  logic        stall_r, stall_s;
  logic        head_r, head_s;
  logic        pclk_r, pclk_s;
  logic        set_r, set_s;
  logic        p_reset_r, p_reset_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        underrun_r, underrun_s;
  logic        begin_bit_s;
  logic        clear_s;

  // Next-state, buffering and output-register logic
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    bits_left_s  = bits_left_r;
    sh_s         = sh_r;
    hold_s       = hold_r;
    sh_cnt_s     = sh_cnt_r;
    hold_empty_s = hold_empty_r;
    stall_s      = stall_r;
    head_s       = head_r;
    pclk_s       = pclk_r;
    set_s        = set_r;
    p_reset_s    = p_reset_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    underrun_s   = underrun_r;
    begin_bit_s  = 1'b0;
    clear_s      = 1'b0;

    // An empty shift register refills one cycle later; reload and write are exclusive
    if ((sh_cnt_r == 6'd0) && !hold_empty_r) begin
      sh_s         = hold_r;
      sh_cnt_s     = 6'd32;
      hold_empty_s = 1'b1;
    end else if (wr_valid && hold_empty_r) begin
      hold_s       = wr_data;
      hold_empty_s = 1'b0;
    end else begin
      hold_s       = hold_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s     = ST_FRESET;
          p_reset_s   = 1'b1;
          cnt_s       = 16'd1;
          bits_left_s = total_bits;
          underrun_s  = 1'b0;
          stall_s     = 1'b0;
          busy_s      = 1'b1;
        end else begin
          state_s     = ST_IDLE;
        end
      end
      ST_FRESET: begin
        if (cnt_r == RST_LAST) begin
          p_reset_s = 1'b0;
          if (bits_left_r == 16'd0) begin
            state_s = ST_LATCH;
            set_s   = 1'b1;
            cnt_s   = 16'd1;
          end else begin
            state_s     = ST_SHIFT;
            begin_bit_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_SHIFT: begin
        if (stall_r) begin
          begin_bit_s = 1'b1;
        end else if (!pclk_r) begin
          if (cnt_r == DIV_LAST) begin
            pclk_s      = 1'b1;
            cnt_s       = 16'd1;
            bits_left_s = bits_left_r - 16'd1;
          end else begin
            cnt_s = cnt_r + 16'd1;
          end
        end else begin
          if (cnt_r == DIV_LAST) begin
            pclk_s = 1'b0;
            if (bits_left_r == 16'd0) begin
              state_s = ST_LATCH;
              set_s   = 1'b1;
              cnt_s   = 16'd1;
            end else begin
              begin_bit_s = 1'b1;
            end
          end else begin
            cnt_s = cnt_r + 16'd1;
          end
        end
      end
      ST_LATCH: begin
        if (cnt_r == LAT_LAST) begin
          set_s   = 1'b0;
          done_s  = 1'b1;
          state_s = ST_DONE;
          clear_s = 1'b1;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        cnt_s   = 16'd0;
      end
      default: begin
        state_s   = ST_IDLE;
        busy_s    = 1'b0;
        pclk_s    = 1'b0;
        set_s     = 1'b0;
        p_reset_s = 1'b0;
      end
    endcase

    // A bit period starts only with data in hand; otherwise the clock idles low
    if (begin_bit_s) begin
      pclk_s = 1'b0;
      if (sh_cnt_r != 6'd0) begin
        head_s   = sh_r[31];
        sh_s     = {sh_r[30:0], 1'b0};
        sh_cnt_s = sh_cnt_r - 6'd1;
        stall_s  = 1'b0;
        cnt_s    = 16'd1;
      end else begin
        stall_s    = 1'b1;
        underrun_s = 1'b1;
      end
    end else begin
      stall_s = stall_s;
    end

    if (clear_s) begin
      sh_s         = 32'd0;
      sh_cnt_s     = 6'd0;
      hold_s       = 32'd0;
      hold_empty_s = 1'b1;
      stall_s      = 1'b0;
    end else begin
      hold_empty_s = hold_empty_s;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 16'd0;
      bits_left_r  <= 16'd0;
      sh_r         <= 32'd0;
      hold_r       <= 32'd0;
      sh_cnt_r     <= 6'd0;
      hold_empty_r <= 1'b1;
      stall_r      <= 1'b0;
      head_r       <= 1'b0;
      pclk_r       <= 1'b0;
      set_r        <= 1'b0;
      p_reset_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      bits_left_r  <= bits_left_s;
      sh_r         <= sh_s;
      hold_r       <= hold_s;
      sh_cnt_r     <= sh_cnt_s;
      hold_empty_r <= hold_empty_s;
      stall_r      <= stall_s;
      head_r       <= head_s;
      pclk_r       <= pclk_s;
      set_r        <= set_s;
      p_reset_r    <= p_reset_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      underrun_r   <= underrun_s;
    end
  end

  assign wr_ready          = hold_empty_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign underrun          = underrun_r;
  assign head              = head_r;
  assign programming_clock = pclk_r;
  assign set               = set_r;
  assign p_reset           = p_reset_r;

endmodule
